fetch_unit: RTL and testbench

Program counter and instruction-fetch sequencer for the 9-bit accumulator core. It drives the instruction ROM address and takes the control decoder's `BRANCH`, `LOOKUP2` and `done` outputs, plus the ALU `ZERO` flag, to compute the next PC every cycle. It supports relative and lookup-table branches, start/halt sequencing and a run-cycle counter.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer for the 9-bit accumulator core.
// Computes the next PC from decoder branch requests, a 16-entry target LUT and start/halt control.
module fetch_unit #(
   parameter int PC_W      = 10,
   parameter int LUT_DEPTH = 16,
   parameter int CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [PC_W-1:0]   START_ADDR,
   input  logic [8:0]        INSTR,
   input  logic              BRANCH,
   input  logic              LOOKUP2,
   input  logic              ZERO,
   input  logic              DONE_IN,
   input  logic              LUT_WE,
   input  logic [3:0]        LUT_WADDR,
   input  logic [PC_W-1:0]   LUT_WDATA,
   output logic [PC_W-1:0]   PC,
   output logic              FETCH_EN,
   output logic              HALTED,
   output logic [CNT_W-1:0]  CYCLE_CNT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PC_W-1:0]   lut_q [LUT_DEPTH];
   logic [LUT_DEPTH-1:0] lut_wsel;
   logic [PC_W-1:0]   offset_ext;
   logic [PC_W-1:0]   lut_target;

   // The opcode MSB plays no part in PC sequencing.
   logic unused_instr_msb;
   assign unused_instr_msb = INSTR[8];

   genvar gi;
   generate
      for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut_wsel
         assign lut_wsel[gi] = LUT_WE && (LUT_WADDR == 4'(gi));
      end
   endgenerate

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
         if (RESET) begin
            lut_q[i] <= '0;
         end else if (lut_wsel[i]) begin
            lut_q[i] <= LUT_WDATA;
         end
      end
   end

   assign lut_target = lut_q[INSTR[3:0]];
   assign offset_ext = {{(PC_W-8){INSTR[7]}}, INSTR[7:0]};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (DONE_IN) begin
               state_d = S_HALT;
            end else if (BRANCH && ZERO && LOOKUP2) begin
               pc_d = lut_target;
            end else if (BRANCH && ZERO) begin
               pc_d = pc_q + offset_ext;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: begin
            // IDLE and HALT share the start/restart behaviour.
            if (START) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PC        = pc_q;
   assign FETCH_EN  = (state_q == S_RUN);
   assign HALTED    = (state_q == S_HALT);
   assign CYCLE_CNT = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model pushes expected outputs per cycle,
// which are popped and compared one cycle later; a CNT_W=4 instance covers saturation.
module tb_fetch_unit;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, br, lk, z, done_in, lut_we;
   logic [9:0] start_addr, lut_wdata;
   logic [8:0] instr;
   logic [3:0] lut_waddr;

   logic [9:0]  pc, pc4;
   logic        fe, fe4, halted, halted4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .CNT_W(16)) dut (
      .CLK(clk), .RESET(rst), .START(start), .START_ADDR(start_addr), .INSTR(instr),
      .BRANCH(br), .LOOKUP2(lk), .ZERO(z), .DONE_IN(done_in), .LUT_WE(lut_we),
      .LUT_WADDR(lut_waddr), .LUT_WDATA(lut_wdata),
      .PC(pc), .FETCH_EN(fe), .HALTED(halted), .CYCLE_CNT(cnt)
   );

   fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .CNT_W(4)) dut4 (
      .CLK(clk), .RESET(rst), .START(start), .START_ADDR(start_addr), .INSTR(instr),
      .BRANCH(br), .LOOKUP2(lk), .ZERO(z), .DONE_IN(done_in), .LUT_WE(lut_we),
      .LUT_WADDR(lut_waddr), .LUT_WDATA(lut_wdata),
      .PC(pc4), .FETCH_EN(fe4), .HALTED(halted4), .CYCLE_CNT(cnt4)
   );

   typedef struct packed {
      logic [9:0]  pc;
      logic        fe;
      logic        h;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   typedef enum int {M_IDLE, M_RUN, M_HALT} mst_t;

   exp_t       sb_q[$];
   mst_t       m_st;
   logic [9:0] m_pc;
   int         m_cnt, m_cnt4;
   logic [9:0] m_lut [16];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_inputs();
      rst = 1'b0; start = 1'b0; br = 1'b0; lk = 1'b0; z = 1'b0; done_in = 1'b0;
      lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 10'd0; instr = 9'd0;
   endtask

   // Advance the model on the currently driven inputs, push its prediction,
   // clock the DUT and compare against the popped prediction.
   task automatic step(input string tag);
      exp_t e;
      int   o;
      if (rst) begin
         m_st = M_IDLE; m_pc = '0; m_cnt = 0; m_cnt4 = 0;
         for (int i = 0; i < 16; i++) m_lut[i] = '0;
      end else begin
         if (m_st == M_RUN) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            if (done_in) m_st = M_HALT;
            else if (br && z && lk) m_pc = m_lut[instr[3:0]];
            else if (br && z) begin
               o = int'(instr[7:0]);
               if (o > 127) o -= 256;
               m_pc = 10'((int'(m_pc) + o + 1024) % 1024);
            end else m_pc = 10'((int'(m_pc) + 1) % 1024);
         end else if (start) begin
            m_pc = start_addr; m_cnt = 0; m_cnt4 = 0; m_st = M_RUN;
         end
         if (lut_we) m_lut[lut_waddr] = lut_wdata;
      end
      e.pc = m_pc; e.fe = (m_st == M_RUN); e.h = (m_st == M_HALT);
      e.cnt = 16'(m_cnt); e.cnt4 = 4'(m_cnt4);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
         chk({tag, "_fetch_en"}, 32'(fe), 32'(e.fe));
         chk({tag, "_halted"}, 32'(halted), 32'(e.h));
         chk({tag, "_cnt"}, 32'(cnt), 32'(e.cnt));
         chk({tag, "_cnt4"}, 32'(cnt4), 32'(e.cnt4));
      end
      $display("[%0t] %-14s pc=%03h fe=%0b halted=%0b cnt=%0d cnt4=%0d", $time, tag, pc, fe, halted, cnt, cnt4);
      clear_inputs();
   endtask

   task automatic goto(input logic [9:0] addr);
      done_in = 1'b1;
      step("halt");
      start = 1'b1; start_addr = addr;
      step("start");
   endtask

   initial begin
      clear_inputs();
      start_addr = 10'd0;

      rst = 1'b1;
      step("reset");
      chk("reset_pc_const", 32'(pc), 32'h0);
      chk("reset_cnt_const", 32'(cnt), 32'h0);

      // Sequential fetch from 0x005.
      start = 1'b1; start_addr = 10'h005;
      step("start5");
      chk("start_pc_const", 32'(pc), 32'h005);
      for (int i = 0; i < 3; i++) step("seq");
      chk("seq_pc_const", 32'(pc), 32'h008);
      chk("seq_cnt_const", 32'(cnt), 32'd3);

      // Relative branch taken / not taken.
      goto(10'h010);
      instr = 9'h1FC; br = 1'b1; z = 1'b1;
      step("rel_taken");
      chk("rel_taken_const", 32'(pc), 32'h00C);
      goto(10'h010);
      instr = 9'h1FC; br = 1'b1; z = 1'b0;
      step("rel_nottaken");
      chk("rel_nottaken_const", 32'(pc), 32'h011);

      // LUT branch with a colliding write in the same cycle.
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h2A0;
      step("lut_wr");
      goto(10'h001);
      instr = 9'h033; br = 1'b1; lk = 1'b1; z = 1'b1;
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h100;
      step("lut_br_coll");
      chk("lut_old_value_const", 32'(pc), 32'h2A0);
      goto(10'h001);
      instr = 9'h033; br = 1'b1; lk = 1'b1; z = 1'b1;
      step("lut_br_new");
      chk("lut_new_value_const", 32'(pc), 32'h100);

      // Wrap-around at both ends.
      goto(10'h3FF);
      step("wrap_inc");
      chk("wrap_inc_const", 32'(pc), 32'h000);
      goto(10'h002);
      instr = 9'h0FC; br = 1'b1; z = 1'b1;
      step("wrap_neg");
      chk("wrap_neg_const", 32'(pc), 32'h3FE);

      // DONE beats a taken branch; then restart from 0.
      goto(10'h020);
      done_in = 1'b1; br = 1'b1; z = 1'b1; instr = 9'h005;
      step("done_br");
      chk("done_pc_const", 32'(pc), 32'h020);
      chk("done_halted_const", 32'(halted), 32'd1);
      br = 1'b1; z = 1'b1; instr = 9'h005;
      step("halt_hold");
      start = 1'b1; start_addr = 10'h000;
      step("restart");
      chk("restart_cnt_const", 32'(cnt), 32'd0);

      // Counter saturation on the narrow instance.
      for (int i = 0; i < 20; i++) step("sat_run");
      chk("sat_cnt4_const", 32'(cnt4), 32'd15);
      chk("sat_cnt16_const", 32'(cnt), 32'd20);

      // Reset mid-run dominates START and LUT writes; LUT comes back cleared.
      rst = 1'b1; start = 1'b1; lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h155;
      step("reset_mid");
      chk("reset_mid_fe_const", 32'(fe), 32'd0);
      chk("reset_mid_pc_const", 32'(pc), 32'h0);
      start = 1'b1; start_addr = 10'h001;
      step("start_post");
      instr = 9'h033; br = 1'b1; lk = 1'b1; z = 1'b1;
      step("lut_cleared");
      chk("lut_cleared_const", 32'(pc), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
